norm_sequencer: RTL and testbench
=================================

NORM_SEQUENCER -- requirements
Module: norm_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter NCH, default 8, the number of sensor channels per frame; it SHALL be fixed at 8 for this release.
REQ-002 The block SHALL have parameter TIMEOUT, default 12, the maximum number of WAIT cycles before abort; its legal range SHALL be 2..255.

Ports (name  direction  width  meaning):
REQ-003 The block SHALL have port i_clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_smp_valid  in  1  raw sample present.
REQ-006 The block SHALL have port i_smp_ch  in  3  channel index of the sample.
REQ-007 The block SHALL have port i_smp_data  in  16  raw integer sample.
REQ-008 The block SHALL have port o_smp_ready  out  1  sample accepted when high together with i_smp_valid.
REQ-009 The block SHALL have port o_norm_start  out  1  single-cycle start pulse to the normalizer.
REQ-010 The block SHALL have port o_norm_data  out  16 x NCH  frame presented to the normalizer.
REQ-011 The block SHALL have port i_norm_finished  in  1  normalizer done pulse.
REQ-012 The block SHALL have port i_norm_out  in  16 x NCH  normalizer fixed-point result.
REQ-013 The block SHALL have port o_feat  out  16 x NCH  captured normalized frame.
REQ-014 The block SHALL have port o_feat_valid  out  1  o_feat is valid.
REQ-015 The block SHALL have port i_feat_ready  in  1  downstream consumes o_feat.
REQ-016 The block SHALL have port o_timeout  out  1  one-cycle abort pulse.
REQ-017 The block SHALL have port o_busy  out  1  high in any state other than COLLECT.

Function
REQ-018 All outputs SHALL be driven from registers or decoded from the registered state only; no output SHALL be combinational from an input.
REQ-019 The FSM SHALL have exactly the states COLLECT, START, WAIT and OUT.
REQ-020 In COLLECT, o_smp_ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 In COLLECT, an accepted sample SHALL be written to frame[i_smp_ch] and SHALL set mask[i_smp_ch].
REQ-022 A repeated channel SHALL overwrite frame[i_smp_ch] and SHALL leave the mask unchanged.
REQ-023 When an accept makes mask all-ones, the FSM SHALL enter START on the next edge.
REQ-024 o_norm_start SHALL be 1 for exactly the single cycle spent in START; the FSM SHALL then enter WAIT and clear the timer.
REQ-025 o_norm_data SHALL equal frame at all times.
REQ-026 frame SHALL be stable from entry to START until the FSM returns to COLLECT.
REQ-027 In WAIT, i_norm_finished=1 SHALL capture i_norm_out into o_feat on that edge and SHALL enter OUT.
REQ-028 In WAIT with i_norm_finished=0, the timer SHALL increment each cycle.
REQ-029 When the timer reaches TIMEOUT-1 with no finished, the block SHALL pulse o_timeout for 1 cycle, clear mask, leave o_feat unchanged, and enter COLLECT.
REQ-030 If i_norm_finished=1 in the same cycle the timeout would fire, finished SHALL win and no timeout SHALL be raised.
REQ-031 In OUT, o_feat_valid SHALL be 1 and o_feat SHALL be held until i_feat_ready=1.
REQ-032 On the i_feat_ready=1 edge in OUT, the block SHALL clear o_feat_valid and mask and SHALL enter COLLECT.
REQ-033 i_norm_finished outside WAIT SHALL be ignored.
REQ-034 Minimum latency SHALL be: last sample accepted at edge T -> o_norm_start high in cycle T+1 -> o_feat_valid high the cycle after the finished edge.
REQ-035 The timer SHALL be 8 bits wide; it SHALL neither wrap nor saturate, because the timeout exits WAIT first.
REQ-036 Data SHALL pass through unmodified: no sign extension, arithmetic or reordering of channels.

Reset
REQ-037 Asserting i_rst_n=0 at any time, including mid-WAIT or mid-OUT, SHALL immediately force state=COLLECT, mask=0, frame=0, o_feat=0, timer=0, o_norm_start=0, o_feat_valid=0, o_timeout=0 and o_busy=0.
REQ-038 After i_rst_n is deasserted, o_smp_ready SHALL be 1 from the first cycle.
REQ-039 A normalizer finished pulse arriving after reset SHALL be ignored, because the FSM is no longer in WAIT.

Verification
REQ-040 The bench SHALL cover: channels 0..7 sent back-to-back with data 0x0100+ch, normalizer model finishes 3 cycles after start with out[k]=k -> exactly one o_norm_start, o_feat[k]=k, o_feat_valid until ready.
REQ-041 The bench SHALL cover: channel 2 sent twice (0x0011 then 0x0022), then channels 0,1,3..7 -> o_norm_data[2]=0x0022, with start only after channel 7.
REQ-042 The bench SHALL cover: TIMEOUT=12, normalizer silent -> o_timeout pulses 12 cycles after start, o_feat_valid stays 0, o_smp_ready returns to 1.
REQ-043 The bench SHALL cover: finished arriving on the exact timeout cycle -> no o_timeout, frame captured.
REQ-044 The bench SHALL cover: i_feat_ready held 0 for 20 cycles in OUT -> o_feat stable, o_smp_ready=0, extra finished pulses ignored.
REQ-045 The bench SHALL cover: i_rst_n asserted 2 cycles after start -> all outputs 0 immediately, and a finished pulse after release is ignored.

Source files
------------

// File: rtl/norm_sequencer_if.sv
// Bundle of sample-input, normalizer and feature-output signals around the norm sequencer.
// The master modport is the sequencer itself; the slave modport is its environment.
interface norm_sequencer_if #(
    parameter int NCH = 8
);
    logic                  i_smp_valid;
    logic [2:0]            i_smp_ch;
    logic [15:0]           i_smp_data;
    logic                  o_smp_ready;
    logic                  o_norm_start;
    logic [NCH-1:0][15:0]  o_norm_data;
    logic                  i_norm_finished;
    logic [NCH-1:0][15:0]  i_norm_out;
    logic [NCH-1:0][15:0]  o_feat;
    logic                  o_feat_valid;
    logic                  i_feat_ready;
    logic                  o_timeout;
    logic                  o_busy;

    modport master (
        input  i_smp_valid, i_smp_ch, i_smp_data,
        input  i_norm_finished, i_norm_out, i_feat_ready,
        output o_smp_ready, o_norm_start, o_norm_data,
        output o_feat, o_feat_valid, o_timeout, o_busy
    );

    modport slave (
        output i_smp_valid, i_smp_ch, i_smp_data,
        output i_norm_finished, i_norm_out, i_feat_ready,
        input  o_smp_ready, o_norm_start, o_norm_data,
        input  o_feat, o_feat_valid, o_timeout, o_busy
    );
endinterface

// File: rtl/norm_sequencer.sv
// Gathers one sample per channel into a frame, hands it to the normalizer,
// waits (bounded) for the result and holds the normalized frame until consumed.
module norm_sequencer #(
    parameter int NCH     = 8,
    parameter int TIMEOUT = 12
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    norm_sequencer_if.master   bus
);
    typedef enum logic [1:0] {COLLECT, START, WAIT, OUT} state_t;

    localparam logic [NCH-1:0] MASK_FULL  = {NCH{1'b1}};
    localparam logic [7:0]     TIMER_LAST = 8'(TIMEOUT - 1);

    state_t               state, next_state;
    logic [NCH-1:0]       mask, new_mask;
    logic [NCH-1:0][15:0] frame;
    logic [NCH-1:0][15:0] feat;
    logic [7:0]           timer;
    logic                 timeout_q;
    logic                 accept, capture, timeout_fire, release_out;

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        capture      = 1'b0;
        timeout_fire = 1'b0;
        release_out  = 1'b0;
        new_mask     = mask;
        new_mask[bus.i_smp_ch] = 1'b1;
        case (state)
            COLLECT: begin
                accept = bus.i_smp_valid;
                if (accept && (new_mask == MASK_FULL)) next_state = START;
            end
            START: next_state = WAIT;
            // A finished pulse on the last allowed WAIT cycle takes priority over the abort.
            WAIT: begin
                if (bus.i_norm_finished) begin
                    capture    = 1'b1;
                    next_state = OUT;
                end else if (timer == TIMER_LAST) begin
                    timeout_fire = 1'b1;
                    next_state   = COLLECT;
                end
            end
            OUT: begin
                if (bus.i_feat_ready) begin
                    release_out = 1'b1;
                    next_state  = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= COLLECT;
            mask      <= '0;
            frame     <= '0;
            feat      <= '0;
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            timeout_q <= timeout_fire;
            if (accept) begin
                frame[bus.i_smp_ch] <= bus.i_smp_data;
                mask                <= new_mask;
            end else if (timeout_fire || release_out) begin
                mask <= '0;
            end
            if (capture) feat <= bus.i_norm_out;
            // Timer never wraps: WAIT is left once it reaches TIMER_LAST.
            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT && !bus.i_norm_finished) begin
                timer <= timer + 8'd1;
            end
        end
    end

    assign bus.o_smp_ready  = (state == COLLECT);
    assign bus.o_busy       = (state != COLLECT);
    assign bus.o_norm_start = (state == START);
    assign bus.o_feat_valid = (state == OUT);
    assign bus.o_norm_data  = frame;
    assign bus.o_feat       = feat;
    assign bus.o_timeout    = timeout_q;
endmodule

// File: tb/tb_norm_sequencer.sv
// Directed bench for norm_sequencer: full frames, repeated channels, timeout,
// finished-on-timeout race, back-pressure in OUT and reset mid-WAIT.
module tb_norm_sequencer;
    localparam int NCH     = 8;
    localparam int TIMEOUT = 12;
    localparam int W       = 16 * NCH;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   start_count = 0;
    logic [NCH-1:0][15:0] exp_frame;
    logic [NCH-1:0][15:0] held_feat;

    always #5 i_clk = ~i_clk;

    norm_sequencer_if #(.NCH(NCH)) bus ();

    norm_sequencer #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always @(negedge i_clk) if (bus.o_norm_start === 1'b1) start_count++;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] frameOf(input logic [15:0] base);
        logic [NCH-1:0][15:0] f;
        for (int k = 0; k < NCH; k++) f[k] = base + 16'(k);
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] ch, input logic [15:0] d);
        bus.i_smp_valid = v;
        bus.i_smp_ch    = ch;
        bus.i_smp_data  = d;
    endtask

    task automatic sendSample(input logic [2:0] ch, input logic [15:0] d);
        applyStimulus(1'b1, ch, d);
        tick();
        applyStimulus(1'b0, 3'd0, 16'd0);
    endtask

    task automatic sendFrame(input logic [15:0] base);
        for (int k = 0; k < NCH; k++) sendSample(3'(k), base + 16'(k));
    endtask

    initial begin
        applyStimulus(1'b0, 3'd0, 16'd0);
        bus.i_norm_finished = 1'b0;
        bus.i_norm_out      = '0;
        bus.i_feat_ready    = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_busy",   W'(bus.o_busy),       W'(0));
        checkOutput("rst_start",  W'(bus.o_norm_start), W'(0));
        checkOutput("rst_valid",  W'(bus.o_feat_valid), W'(0));
        checkOutput("rst_tmo",    W'(bus.o_timeout),    W'(0));
        checkOutput("rst_feat",   bus.o_feat,           W'(0));
        checkOutput("rst_ndata",  bus.o_norm_data,      W'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checkOutput("rel_ready",  W'(bus.o_smp_ready),  W'(1));

        // Full frame, normalizer done 3 cycles after start
        sendFrame(16'h0100);
        checkOutput("s1_start",   W'(bus.o_norm_start), W'(1));
        checkOutput("s1_ndata",   bus.o_norm_data,      frameOf(16'h0100));
        checkOutput("s1_sready",  W'(bus.o_smp_ready),  W'(0));
        tick();
        checkOutput("s1_start_off", W'(bus.o_norm_start), W'(0));
        tick();
        tick();
        bus.i_norm_finished = 1'b1;
        bus.i_norm_out      = frameOf(16'h0000);
        tick();
        bus.i_norm_finished = 1'b0;
        checkOutput("s1_valid",   W'(bus.o_feat_valid), W'(1));
        checkOutput("s1_feat",    bus.o_feat,           frameOf(16'h0000));
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("s1_hold_valid", W'(bus.o_feat_valid), W'(1));
        end
        bus.i_feat_ready = 1'b1;
        tick();
        bus.i_feat_ready = 1'b0;
        checkOutput("s1_valid_clr", W'(bus.o_feat_valid), W'(0));
        checkOutput("s1_sready_back", W'(bus.o_smp_ready), W'(1));
        checkOutput("s1_start_count", W'(start_count), W'(1));

        // Channel 2 repeated; start only after channel 7
        sendSample(3'd2, 16'h0011);
        sendSample(3'd2, 16'h0022);
        sendSample(3'd0, 16'h0200);
        sendSample(3'd1, 16'h0201);
        for (int k = 3; k < 7; k++) sendSample(3'(k), 16'h0200 + 16'(k));
        checkOutput("s2_no_start", W'(bus.o_norm_start), W'(0));
        checkOutput("s2_sready",   W'(bus.o_smp_ready),  W'(1));
        sendSample(3'd7, 16'h0207);
        exp_frame    = frameOf(16'h0200);
        exp_frame[2] = 16'h0022;
        checkOutput("s2_start",    W'(bus.o_norm_start), W'(1));
        checkOutput("s2_ndata",    bus.o_norm_data,      exp_frame);
        tick();
        bus.i_norm_finished = 1'b1;
        bus.i_norm_out      = frameOf(16'hA000);
        tick();
        bus.i_norm_finished = 1'b0;
        held_feat = frameOf(16'hA000);
        checkOutput("s2_feat",     bus.o_feat,           held_feat);

        // Back-pressure in OUT for 20 cycles with stray finished pulses
        for (int i = 0; i < 20; i++) begin
            bus.i_norm_finished = (i == 5 || i == 12);
            bus.i_norm_out      = frameOf(16'hD000);
            tick();
            checkOutput("bp_feat",   bus.o_feat,           held_feat);
            checkOutput("bp_sready", W'(bus.o_smp_ready),  W'(0));
            checkOutput("bp_valid",  W'(bus.o_feat_valid), W'(1));
        end
        bus.i_norm_finished = 1'b0;
        bus.i_feat_ready    = 1'b1;
        tick();
        bus.i_feat_ready    = 1'b0;
        checkOutput("bp_release",  W'(bus.o_feat_valid), W'(0));
        checkOutput("s2_start_count", W'(start_count), W'(2));

        // Silent normalizer: 12 WAIT cycles, then abort pulse
        sendFrame(16'h0300);
        checkOutput("s3_start",    W'(bus.o_norm_start), W'(1));
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            checkOutput("s3_no_tmo",   W'(bus.o_timeout),    W'(0));
            checkOutput("s3_valid0",   W'(bus.o_feat_valid), W'(0));
        end
        tick();
        checkOutput("s3_tmo",      W'(bus.o_timeout),    W'(1));
        checkOutput("s3_sready",   W'(bus.o_smp_ready),  W'(1));
        checkOutput("s3_busy",     W'(bus.o_busy),       W'(0));
        checkOutput("s3_feat_kept", bus.o_feat,          held_feat);
        tick();
        checkOutput("s3_tmo_pulse", W'(bus.o_timeout),   W'(0));

        // Mask cleared by the abort; finished lands on the last WAIT cycle
        for (int k = 0; k < 7; k++) sendSample(3'(k), 16'h0400 + 16'(k));
        checkOutput("s4_no_start", W'(bus.o_norm_start), W'(0));
        sendSample(3'd7, 16'h0407);
        checkOutput("s4_start",    W'(bus.o_norm_start), W'(1));
        for (int i = 1; i <= TIMEOUT; i++) tick();
        bus.i_norm_finished = 1'b1;
        bus.i_norm_out      = frameOf(16'hB000);
        tick();
        bus.i_norm_finished = 1'b0;
        checkOutput("s4_no_tmo",   W'(bus.o_timeout),    W'(0));
        checkOutput("s4_valid",    W'(bus.o_feat_valid), W'(1));
        checkOutput("s4_feat",     bus.o_feat,           frameOf(16'hB000));
        tick();
        checkOutput("s4_no_tmo2",  W'(bus.o_timeout),    W'(0));
        bus.i_feat_ready = 1'b1;
        tick();
        bus.i_feat_ready = 1'b0;

        // Reset asserted 2 cycles after start, stray finished afterwards
        sendFrame(16'h0500);
        tick();
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("r_busy",      W'(bus.o_busy),       W'(0));
        checkOutput("r_start",     W'(bus.o_norm_start), W'(0));
        checkOutput("r_valid",     W'(bus.o_feat_valid), W'(0));
        checkOutput("r_tmo",       W'(bus.o_timeout),    W'(0));
        checkOutput("r_feat",      bus.o_feat,           W'(0));
        checkOutput("r_ndata",     bus.o_norm_data,      W'(0));
        checkOutput("r_sready",    W'(bus.o_smp_ready),  W'(1));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        bus.i_norm_finished = 1'b1;
        bus.i_norm_out      = frameOf(16'hE000);
        tick();
        bus.i_norm_finished = 1'b0;
        checkOutput("r_fin_ignored", W'(bus.o_feat_valid), W'(0));
        checkOutput("r_feat_zero",   bus.o_feat,           W'(0));
        checkOutput("r_busy_after",  W'(bus.o_busy),       W'(0));
        checkOutput("total_starts",  W'(start_count),      W'(5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
